pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL accept the parameter DATA_W, default 96, the width of the datapath payload (operands, PC, immediate, register indices).
REQ-002 The block SHALL accept the parameter CTRL_W, default 12, the width of the control payload that is zeroed on flush.
REQ-003 The block SHALL accept the parameter SKID, default 1: 1 selects a two-entry skid buffer with registered in_ready; 0 selects a single register with combinational in_ready.
REQ-004 The block SHALL accept the parameter CNT_W, default 16, the width of the statistics counters.
REQ-005 The block SHALL have the port clk, input, 1 bit: the single clock, with all state updated on the rising edge.
REQ-006 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have the port flush, input, 1 bit: discard all held entries and insert a bubble.
REQ-008 The block SHALL have the ports in_valid (input, 1 bit) and in_ready (output, 1 bit): the upstream handshake.
REQ-009 The block SHALL have the ports in_data (input, DATA_W bits) and in_ctrl (input, CTRL_W bits): the upstream payload.
REQ-010 The block SHALL have the ports out_valid (output, 1 bit) and out_ready (input, 1 bit): the downstream handshake.
REQ-011 The block SHALL have the ports out_data (output, DATA_W bits) and out_ctrl (output, CTRL_W bits): the downstream payload.
REQ-012 The block SHALL have the port stall_cnt, output, CNT_W bits: count of cycles with out_valid=1 and out_ready=0.
REQ-013 The block SHALL have the port flush_cnt, output, CNT_W bits: count of accepted flushes.

Function
REQ-014 Transfers SHALL occur only on valid&&ready, on both sides; payload SHALL NOT be lost or duplicated.
REQ-015 Latency from input transfer to out_valid SHALL be exactly 1 cycle when the block is empty.
REQ-016 For SKID=1, the controller SHALL have the states EMPTY, FULL (main slot valid) and SKID (main and skid slots valid).
REQ-017 SKID=1 transitions: EMPTY->FULL on in transfer; FULL->EMPTY on out transfer with no in transfer; FULL->SKID on in transfer with out_ready=0; SKID->FULL on out transfer, with the skid entry moving to main.
REQ-018 For SKID=1, in_ready SHALL be a flop output equal to 1 in EMPTY/FULL and 0 in SKID.
REQ-019 For SKID=0, in_ready SHALL equal out_ready || !out_valid, and the register SHALL load on in transfer.
REQ-020 While out_valid=1 and out_ready=0, out_data and out_ctrl SHALL be held stable.
REQ-021 Flush SHALL have priority over all handshakes: the next state is EMPTY, both slots are invalidated, and the stored ctrl is set to 0.
REQ-022 On flush, stored data SHALL be held unchanged.
REQ-023 An in_valid presented in the same cycle as flush SHALL be dropped; in_ready SHALL still read as its normal value, and the drop is intentional.
REQ-024 When out_valid=0, out_ctrl SHALL be 0, so a bubble never carries RegWrite/MemWrite/Branch/Jump.
REQ-025 stall_cnt and flush_cnt SHALL increment by 1 per qualifying cycle and saturate at 2^CNT_W-1, with no wrap.
REQ-026 A flush during a stall cycle SHALL count in flush_cnt; stall_cnt SHALL count that cycle only if out_valid=1 before the edge.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state EMPTY, out_valid=0, out_data=0, out_ctrl=0, skid contents=0, stall_cnt=0 and flush_cnt=0.
REQ-028 During reset, in_ready SHALL be 0 for SKID=1; it SHALL be 1 from the first rising edge after rst_n rises.
REQ-029 Reset asserted mid-transfer SHALL discard all held entries, with no partial payload visible afterwards.

Structure
REQ-030 A shared package pipe_pkg SHALL hold the state enum (EMPTY/FULL/SKID) and the default DATA_W/CTRL_W/CNT_W constants.
REQ-031 One sub-module, pipe_slot, SHALL implement a single valid+data+ctrl register with load, clear-ctrl and async reset; it is instantiated once for SKID=0 and twice for SKID=1.
REQ-032 The counters SHALL be inline, with no further hierarchy.

Verification
REQ-033 Reset, then in_valid=1 with data 0xA5 and out_ready=1 -> out_valid=1 with out_data=0xA5 one cycle later; stall_cnt=0.
REQ-034 SKID=1, out_ready=0, two back-to-back inputs D1 and D2 -> state SKID and in_ready=0; then out_ready=1 -> D1 then D2 on consecutive cycles; stall_cnt=2.
REQ-035 In SKID state, flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1, flush_cnt=1, and the new input does not appear.
REQ-036 CNT_W=4, out_ready=0 held for 20 cycles with valid data -> stall_cnt saturates at 15 and the data stays stable.
REQ-037 rst_n asserted asynchronously mid-cycle in FULL -> outputs clear immediately without waiting for clk; recovery after rst_n rises is per REQ-028.
REQ-038 Random valid/ready/flush stimulus for 10k cycles, SKID=0 and SKID=1 -> scoreboard shows in-order, lossless transfer except for flushed entries.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipeline stage register and its slots.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

    localparam int PIPE_DATA_W = 96;
    localparam int PIPE_CTRL_W = 12;
    localparam int PIPE_CNT_W  = 16;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream and downstream valid/ready handshake plus payload of one pipeline stage.
interface pipe_stage_reg_if import pipe_pkg::*; #(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = PIPE_CTRL_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;

    modport master (
        output in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl
    );
endinterface

// File: rtl/pipe_slot.sv
// One valid+data+ctrl holding register; clear drops the entry and zeroes ctrl but keeps data.
module pipe_slot import pipe_pkg::*; #(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = PIPE_CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_valid_d,
    input  logic              i_clr,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl
);
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ctrl  <= '0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else begin
            r_valid <= i_valid_d;
            if (i_load) begin
                r_data <= i_data;
                r_ctrl <= i_ctrl;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_ctrl  = r_ctrl;
endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional skid slot, flush and
// saturating stall/flush statistics.
module pipe_stage_reg import pipe_pkg::*; #(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = PIPE_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    pipe_stage_reg_if.slave  bus,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    logic              w_in_ready;
    logic              w_in_xfer;
    logic              w_out_xfer;
    logic              w_main_load;
    logic              w_main_vld_d;
    logic              w_main_vld;
    logic [DATA_W-1:0] w_main_din;
    logic [DATA_W-1:0] w_main_data;
    logic [CTRL_W-1:0] w_main_cin;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign w_in_xfer  = bus.in_valid && w_in_ready;
    assign w_out_xfer = w_main_vld && bus.out_ready;

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_main_load),
        .i_valid_d (w_main_vld_d),
        .i_clr     (flush),
        .i_data    (w_main_din),
        .i_ctrl    (w_main_cin),
        .o_valid   (w_main_vld),
        .o_data    (w_main_data),
        .o_ctrl    (w_main_ctrl)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_state_e       r_state;
            pipe_state_e       w_state_nxt;
            logic              r_in_ready;
            logic              w_skid_load;
            logic              w_skid_vld;
            logic [DATA_W-1:0] w_skid_data;
            logic [CTRL_W-1:0] w_skid_ctrl;

            pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
                .clk       (clk),
                .rst_n     (rst_n),
                .i_load    (w_skid_load),
                .i_valid_d (w_state_nxt == ST_SKID),
                .i_clr     (flush),
                .i_data    (bus.in_data),
                .i_ctrl    (bus.in_ctrl),
                .o_valid   (w_skid_vld),
                .o_data    (w_skid_data),
                .o_ctrl    (w_skid_ctrl)
            );

            // in_ready is registered from the next state so it never depends on out_ready
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state    <= ST_EMPTY;
                    r_in_ready <= 1'b0;
                end else begin
                    r_state    <= w_state_nxt;
                    r_in_ready <= (w_state_nxt != ST_SKID);
                end
            end

            always_comb begin
                w_state_nxt = r_state;
                if (flush) begin
                    w_state_nxt = ST_EMPTY;
                end else begin
                    case (r_state)
                        ST_EMPTY: if (w_in_xfer) w_state_nxt = ST_FULL;
                        ST_FULL: begin
                            if (w_in_xfer && !bus.out_ready)
                                w_state_nxt = ST_SKID;
                            else if (w_out_xfer && !w_in_xfer)
                                w_state_nxt = ST_EMPTY;
                        end
                        ST_SKID:  if (w_out_xfer) w_state_nxt = ST_FULL;
                        default:  w_state_nxt = ST_EMPTY;
                    endcase
                end
            end

            // A held skid entry always refills main before any new input is taken
            always_comb begin
                w_main_load = 1'b0;
                w_skid_load = 1'b0;
                w_main_din  = w_skid_vld ? w_skid_data : bus.in_data;
                w_main_cin  = w_skid_vld ? w_skid_ctrl : bus.in_ctrl;
                case (r_state)
                    ST_EMPTY: w_main_load = w_in_xfer;
                    ST_FULL: begin
                        w_main_load = w_in_xfer && bus.out_ready;
                        w_skid_load = w_in_xfer && !bus.out_ready;
                    end
                    ST_SKID:  w_main_load = w_out_xfer;
                    default:  w_main_load = 1'b0;
                endcase
            end

            assign w_main_vld_d = (w_state_nxt != ST_EMPTY);
            assign w_in_ready   = r_in_ready;
        end else begin : g_single
            assign w_in_ready   = bus.out_ready || !w_main_vld;
            assign w_main_load  = w_in_xfer;
            assign w_main_vld_d = w_in_xfer || (w_main_vld && !bus.out_ready);
            assign w_main_din   = bus.in_data;
            assign w_main_cin   = bus.in_ctrl;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_main_vld && !bus.out_ready) r_stall_cnt <= sat_inc(r_stall_cnt);
            if (flush)                        r_flush_cnt <= sat_inc(r_flush_cnt);
        end
    end

    // A bubble must never carry live control bits downstream
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_main_vld;
    assign bus.out_data  = w_main_data;
    assign bus.out_ctrl  = w_main_vld ? w_main_ctrl : '0;
    assign stall_cnt     = r_stall_cnt;
    assign flush_cnt     = r_flush_cnt;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table, corner sequences and a queue-model
// scoreboard under random valid/ready/flush for both SKID settings.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int DW = PIPE_DATA_W;
    localparam int CW = PIPE_CTRL_W;
    localparam logic [CW-1:0] CTRL_TAG = 12'hC00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fl_a = 1'b0;
    logic        fl_b = 1'b0;
    logic [3:0]  sc_a, fc_a;
    logic [15:0] sc_c, fc_c, sc_b, fc_b;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) ifa ();
    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) ifb ();
    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) ifc ();

    // dut_c sees exactly the stimulus of dut_a but keeps wide counters
    assign ifc.in_valid  = ifa.in_valid;
    assign ifc.in_data   = ifa.in_data;
    assign ifc.in_ctrl   = ifa.in_ctrl;
    assign ifc.out_ready = ifa.out_ready;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(fl_a), .bus(ifa), .stall_cnt(sc_a), .flush_cnt(fc_a));
    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) dut_c (
        .clk(clk), .rst_n(rst_n), .flush(fl_a), .bus(ifc), .stall_cnt(sc_c), .flush_cnt(fc_c));
    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(fl_b), .bus(ifb), .stall_cnt(sc_b), .flush_cnt(fc_b));

    typedef struct {
        logic       fl;
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       ov;
        logic [7:0] od;
        logic       ir;
        logic [3:0] sc;
        logic [3:0] fc;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        fl_a = 1'b0;
        fl_b = 1'b0;
        ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.in_ctrl = '0; ifa.out_ready = 1'b0;
        ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.in_ctrl = '0; ifb.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid_a", 128'(ifa.out_valid), 128'(0));
        chk("rst_out_data_a",  128'(ifa.out_data),  128'(0));
        chk("rst_out_ctrl_a",  128'(ifa.out_ctrl),  128'(0));
        chk("rst_in_ready_a",  128'(ifa.in_ready),  128'(0));
        chk("rst_stall_a",     128'(sc_a),          128'(0));
        chk("rst_flush_c",     128'(fc_c),          128'(0));
        chk("rst_out_valid_b", 128'(ifb.out_valid), 128'(0));
        chk("rst_in_ready_b",  128'(ifb.in_ready),  128'(1));
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_before_edge", 128'(ifa.in_ready), 128'(0));
        @(posedge clk);
        #1;
        chk("rel_in_ready_after_edge", 128'(ifa.in_ready), 128'(1));
    endtask

    logic [107:0] qa[$];
    logic [107:0] qb[$];
    int           msa, mfa, msb, mfb;
    logic         ea_ov, ea_ir, eb_ov, eb_ir;
    logic [31:0]  r32;
    logic [95:0]  hold_d;

    initial begin
        //                fl    iv    id     ordy  ov    od     ir    sc    fc
        vt[0]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b1, 4'd0, 4'd0};
        vt[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b1, 4'd0, 4'd0};
        vt[2]  = '{1'b0, 1'b1, 8'hD1, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 4'd0};
        vt[3]  = '{1'b0, 1'b1, 8'hD2, 1'b0, 1'b1, 8'hD1, 1'b1, 4'd0, 4'd0};
        vt[4]  = '{1'b0, 1'b1, 8'hEE, 1'b0, 1'b1, 8'hD1, 1'b0, 4'd1, 4'd0};
        vt[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hD1, 1'b0, 4'd2, 4'd0};
        vt[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hD2, 1'b1, 4'd2, 4'd0};
        vt[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 4'd2, 4'd0};
        vt[8]  = '{1'b0, 1'b1, 8'h31, 1'b0, 1'b0, 8'h00, 1'b1, 4'd2, 4'd0};
        vt[9]  = '{1'b0, 1'b1, 8'h32, 1'b0, 1'b1, 8'h31, 1'b1, 4'd2, 4'd0};
        vt[10] = '{1'b1, 1'b1, 8'h33, 1'b0, 1'b1, 8'h31, 1'b0, 4'd3, 4'd0};
        vt[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 4'd4, 4'd1};
        vt[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 4'd4, 4'd1};
        vt[13] = '{1'b1, 1'b1, 8'h44, 1'b1, 1'b0, 8'h00, 1'b1, 4'd4, 4'd1};
        vt[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 4'd4, 4'd2};

        do_reset();

        for (int i = 0; i < 15; i++) begin
            fl_a          = vt[i].fl;
            ifa.in_valid  = vt[i].iv;
            ifa.in_data   = DW'(vt[i].id);
            ifa.in_ctrl   = CW'(vt[i].id) ^ CTRL_TAG;
            ifa.out_ready = vt[i].ordy;
            @(negedge clk);
            chk($sformatf("vec%0d_out_valid", i), 128'(ifa.out_valid), 128'(vt[i].ov));
            chk($sformatf("vec%0d_in_ready", i),  128'(ifa.in_ready),  128'(vt[i].ir));
            chk($sformatf("vec%0d_out_ctrl", i),  128'(ifa.out_ctrl),
                vt[i].ov ? 128'(CW'(vt[i].od) ^ CTRL_TAG) : 128'(0));
            if (vt[i].ov)
                chk($sformatf("vec%0d_out_data", i), 128'(ifa.out_data), 128'(vt[i].od));
            chk($sformatf("vec%0d_stall_a", i), 128'(sc_a), 128'(vt[i].sc));
            chk($sformatf("vec%0d_flush_a", i), 128'(fc_a), 128'(vt[i].fc));
            chk($sformatf("vec%0d_stall_c", i), 128'(sc_c), 128'(vt[i].sc));
            chk($sformatf("vec%0d_flush_c", i), 128'(fc_c), 128'(vt[i].fc));
            @(posedge clk);
            #1;
        end

        // Stall saturation: one entry held for 20 stalled cycles
        do_reset();
        hold_d = 96'h0123_4567_89AB_CDEF_F00D_BEEF;
        ifa.in_valid = 1'b1; ifa.in_data = hold_d; ifa.in_ctrl = 12'h5A5; ifa.out_ready = 1'b0;
        @(posedge clk);
        #1;
        ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.in_ctrl = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk($sformatf("sat%0d_out_data", k), 128'(ifa.out_data), 128'(hold_d));
            chk($sformatf("sat%0d_out_ctrl", k), 128'(ifa.out_ctrl), 128'(12'h5A5));
            chk($sformatf("sat%0d_stall_a", k), 128'(sc_a), 128'((k > 15) ? 15 : k));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("sat_stall_a_final", 128'(sc_a), 128'(15));
        chk("sat_stall_c_final", 128'(sc_c), 128'(20));
        chk("sat_out_valid",     128'(ifa.out_valid), 128'(1));
        @(posedge clk);
        #1;

        // Asynchronous reset in FULL, away from any clock edge
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 128'(ifa.out_valid), 128'(0));
        chk("async_out_data",  128'(ifa.out_data),  128'(0));
        chk("async_out_ctrl",  128'(ifa.out_ctrl),  128'(0));
        chk("async_in_ready",  128'(ifa.in_ready),  128'(0));
        chk("async_stall_a",   128'(sc_a),          128'(0));
        chk("async_stall_c",   128'(sc_c),          128'(0));
        do_reset();

        // Random traffic against a queue model: capacity 2 with SKID=1, 1 with SKID=0
        msa = 0; mfa = 0; msb = 0; mfb = 0;
        qa.delete();
        qb.delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            fl_a          = ($urandom_range(0, 19) == 0);
            ifa.in_valid  = ($urandom_range(0, 9) < 6);
            ifa.in_data   = {$urandom(), $urandom(), $urandom()};
            r32           = $urandom();
            ifa.in_ctrl   = r32[CW-1:0];
            ifa.out_ready = ($urandom_range(0, 9) < 6);
            fl_b          = ($urandom_range(0, 19) == 0);
            ifb.in_valid  = ($urandom_range(0, 9) < 6);
            ifb.in_data   = {$urandom(), $urandom(), $urandom()};
            r32           = $urandom();
            ifb.in_ctrl   = r32[CW-1:0];
            ifb.out_ready = ($urandom_range(0, 9) < 6);
            @(negedge clk);

            ea_ov = (qa.size() > 0);
            ea_ir = (qa.size() < 2);
            chk("rnd_a_out_valid", 128'(ifa.out_valid), 128'(ea_ov));
            chk("rnd_a_in_ready",  128'(ifa.in_ready),  128'(ea_ir));
            chk("rnd_a_out_ctrl",  128'(ifa.out_ctrl),  ea_ov ? 128'(qa[0][11:0]) : 128'(0));
            if (ea_ov) chk("rnd_a_out_data", 128'(ifa.out_data), 128'(qa[0][107:12]));
            chk("rnd_a_stall", 128'(sc_a), 128'((msa > 15) ? 15 : msa));
            chk("rnd_a_flush", 128'(fc_a), 128'((mfa > 15) ? 15 : mfa));
            chk("rnd_c_stall", 128'(sc_c), 128'(msa));
            chk("rnd_c_flush", 128'(fc_c), 128'(mfa));
            if (ea_ov && !ifa.out_ready) msa++;
            if (fl_a) begin
                mfa++;
                qa.delete();
            end else begin
                if (ea_ov && ifa.out_ready) void'(qa.pop_front());
                if (ifa.in_valid && ea_ir) qa.push_back({ifa.in_data, ifa.in_ctrl});
            end

            eb_ov = (qb.size() > 0);
            eb_ir = ifb.out_ready || (qb.size() == 0);
            chk("rnd_b_out_valid", 128'(ifb.out_valid), 128'(eb_ov));
            chk("rnd_b_in_ready",  128'(ifb.in_ready),  128'(eb_ir));
            chk("rnd_b_out_ctrl",  128'(ifb.out_ctrl),  eb_ov ? 128'(qb[0][11:0]) : 128'(0));
            if (eb_ov) chk("rnd_b_out_data", 128'(ifb.out_data), 128'(qb[0][107:12]));
            chk("rnd_b_stall", 128'(sc_b), 128'(msb));
            chk("rnd_b_flush", 128'(fc_b), 128'(mfb));
            if (eb_ov && !ifb.out_ready) msb++;
            if (fl_b) begin
                mfb++;
                qb.delete();
            end else begin
                if (eb_ov && ifb.out_ready) void'(qb.pop_front());
                if (ifb.in_valid && eb_ir) qb.push_back({ifb.in_data, ifb.in_ctrl});
            end

            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
